// File: rtl/pair_engine_arbiter.sv
`timescale 1ns/1ps
// pair_engine_arbiter
// Shares one pair-count engine between two stream requesters. A requester
// owns the engine for a whole frame. After the frame, the engine's running
// pair count and the frame's beat count are returned as one result beat.
// The engine is then cleared before the next arbitration.
module pair_engine_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int LEN_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE-1:0] s0_tdata,
    input  logic                 s0_tvalid,
    input  logic                 s0_tlast,
    output logic                 s0_tready,
    input  logic [DATA_SIZE-1:0] s1_tdata,
    input  logic                 s1_tvalid,
    input  logic                 s1_tlast,
    output logic                 s1_tready,
    output logic [DATA_SIZE-1:0] eng_tdata,
    output logic                 eng_tvalid,
    input  logic                 eng_tready,
    input  logic [DATA_SIZE-1:0] eng_pairs,
    output logic                 eng_clr,
    output logic [DATA_SIZE-1:0] res_tdata,
    output logic [LEN_SIZE-1:0]  res_tlen,
    output logic                 res_tid,
    output logic                 res_tvalid,
    input  logic                 res_tready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        DRAIN  = 3'd2,
        RESULT = 3'd3,
        CLEAR  = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic                grant, grant_nxt;   // 0 = s0, 1 = s1
    logic                last_grant;
    logic [LEN_SIZE-1:0] beat_cnt;
    logic                in_stream;
    logic                sel_valid;
    logic                sel_last;
    logic                xfer;

    // Steer the granted requester straight through to the engine (zero latency).
    always_comb begin
        in_stream  = (state == STREAM);
        sel_valid  = grant ? s1_tvalid : s0_tvalid;
        sel_last   = grant ? s1_tlast  : s0_tlast;
        xfer       = in_stream & sel_valid & eng_tready;
        eng_tdata  = grant ? s1_tdata : s0_tdata;
        eng_tvalid = in_stream & sel_valid;
        s0_tready  = in_stream & ~grant & eng_tready;
        s1_tready  = in_stream &  grant & eng_tready;
        res_tvalid = (state == RESULT);
        // Reset also holds the engine in clear, so a frame cut by reset never leaks.
        eng_clr    = ~rst_n | (state == CLEAR);
    end

    // Next-state and grant selection; the grant only moves while IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can
        // leave a value unassigned and infer a latch.
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (s0_tvalid | s1_tvalid) begin
                    state_nxt = STREAM;
                    grant_nxt = (s0_tvalid & s1_tvalid) ? ~last_grant : s1_tvalid;
                end
            end
            STREAM: begin
                if (xfer & sel_last) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = RESULT;
            RESULT: begin
                if (res_tready) state_nxt = CLEAR;
            end
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant and fairness history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;   // s0 wins the first tie
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;
            grant <= grant_nxt;
            if (state == IDLE && state_nxt == STREAM) last_grant <= grant_nxt;
        end
    end

    // Beat counter: counts accepted beats, saturates, zeroed while clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (state == CLEAR) begin
            beat_cnt <= '0;
        end else if (xfer && !(&beat_cnt)) begin
            beat_cnt <= beat_cnt + LEN_SIZE'(1);
        end
    end

    // Result capture one cycle after the last beat, once the engine has counted it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_tdata <= '0;
            res_tlen  <= '0;
            res_tid   <= 1'b0;
        end else if (state == DRAIN) begin
            res_tdata <= eng_pairs;
            res_tlen  <= beat_cnt;
            res_tid   <= grant;
        end
    end

endmodule

// File: tb/tb_pair_engine_arbiter.sv
`timescale 1ns/1ps
// Bench for pair_engine_arbiter: behavioural pair-count engine, per-requester
// frame scoreboard, cycle-level protocol monitor, directed and random traffic.
module tb_pair_engine_arbiter;

    localparam int DW      = 8;
    localparam int LW      = 3;              // small so saturation is reachable
    localparam int LEN_MAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s0_tdata, s1_tdata;
    logic          s0_tvalid, s1_tvalid, s0_tlast, s1_tlast;
    logic          s0_tready, s1_tready;
    logic [DW-1:0] eng_tdata;
    logic          eng_tvalid, eng_tready;
    logic [DW-1:0] eng_pairs;
    logic          eng_clr;
    logic [DW-1:0] res_tdata;
    logic [LW-1:0] res_tlen;
    logic          res_tid, res_tvalid, res_tready;

    pair_engine_arbiter #(.DATA_SIZE(DW), .LEN_SIZE(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .eng_tdata(eng_tdata), .eng_tvalid(eng_tvalid), .eng_tready(eng_tready),
        .eng_pairs(eng_pairs), .eng_clr(eng_clr),
        .res_tdata(res_tdata), .res_tlen(res_tlen), .res_tid(res_tid),
        .res_tvalid(res_tvalid), .res_tready(res_tready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Engine stand-in: a value forms a pair each time it has been seen an even number of times.
    logic [255:0] parity;
    always @(posedge clk) begin
        if (eng_clr) begin
            eng_pairs <= '0;
            parity    <= '0;
        end else if (eng_tvalid && eng_tready) begin
            if (parity[eng_tdata]) eng_pairs <= eng_pairs + 8'd1;
            parity[eng_tdata] <= ~parity[eng_tdata];
        end
    end

    typedef struct { int pairs; int len; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int   res_log[$];
    logic [DW-1:0] fix0[$];
    logic [DW-1:0] fix1[$];

    task automatic drive(input int id, input logic v, input logic [DW-1:0] d, input logic l);
        if (id == 0) begin s0_tvalid = v; s0_tdata = d; s0_tlast = l; end
        else         begin s1_tvalid = v; s1_tdata = d; s1_tlast = l; end
    endtask

    // Send one frame from requester id; its expected result goes on that requester's queue.
    task automatic send_frame(input int id, input int nbeats, input int gap, input bit use_fix);
        logic [DW-1:0] beats[$];
        int   cnt[256];
        exp_t e;
        bit   ok;
        int   budget;
        for (int v = 0; v < 256; v++) cnt[v] = 0;
        for (int i = 0; i < nbeats; i++) begin
            if (use_fix) beats.push_back(id == 0 ? fix0[i] : fix1[i]);
            else         beats.push_back(DW'($urandom_range(0, 3)));
            cnt[beats[i]]++;
        end
        e.pairs = 0;
        for (int v = 0; v < 256; v++) e.pairs += cnt[v] / 2;
        e.len = (nbeats > LEN_MAX) ? LEN_MAX : nbeats;
        if (id == 0) q0.push_back(e); else q1.push_back(e);
        repeat (gap) begin @(posedge clk); #1; end
        for (int i = 0; i < nbeats; i++) begin
            drive(id, 1'b1, beats[i], i == nbeats - 1);
            budget = 400;
            do begin
                @(negedge clk);
                ok = (id == 0) ? s0_tready : s1_tready;
                budget--;
            end while (!ok && budget > 0);
            if (!ok) begin
                check("beat_accept_timeout", ok, 1'b1);
                drive(id, 1'b0, '0, 1'b0);
                return;
            end
            @(posedge clk); #1;
        end
        drive(id, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_drain();
        int b = 3000;
        while ((q0.size() + q1.size()) != 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("drain_timeout", q0.size() + q1.size(), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic wait_res_valid();
        int b = 400;
        do begin @(negedge clk); b--; end while (!res_tvalid && b > 0);
        if (!res_tvalid) check("res_valid_timeout", res_tvalid, 1'b1);
    endtask

    // Protocol monitor and result scoreboard, sampled on the falling edge.
    logic          clr_exp = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held_data;
    logic [LW-1:0] held_len;
    logic          held_tid;
    exp_t          e_mon;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("clr_in_reset", eng_clr, 1'b1);
            check("outputs_in_reset",
                  {s0_tready, s1_tready, eng_tvalid, res_tvalid, res_tid, res_tdata, res_tlen}, 0);
            clr_exp    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("tready_exclusive", s0_tready & s1_tready, 1'b0);
            check("tready_without_eng", (s0_tready | s1_tready) & ~eng_tready, 1'b0);
            if (s0_tready) check("eng_data_s0", {eng_tvalid, eng_tdata}, {s0_tvalid, s0_tdata});
            if (s1_tready) check("eng_data_s1", {eng_tvalid, eng_tdata}, {s1_tvalid, s1_tdata});
            if (res_tvalid) check("quiet_in_result", s0_tready | s1_tready | eng_tvalid, 1'b0);
            if (eng_clr) check("quiet_in_clear", s0_tready | s1_tready | eng_tvalid | res_tvalid, 1'b0);
            check("eng_clr", eng_clr, clr_exp);
            if (stall_prev)
                check("res_stable", {res_tvalid, res_tid, res_tdata, res_tlen},
                      {1'b1, held_tid, held_data, held_len});
            if (res_tvalid && res_tready) begin
                res_log.push_back(int'(res_tid));
                check("res_pending", (res_tid ? q1.size() : q0.size()) > 0, 1'b1);
                if ((res_tid ? q1.size() : q0.size()) > 0) begin
                    e_mon = res_tid ? q1.pop_front() : q0.pop_front();
                    check(res_tid ? "res_pairs_s1" : "res_pairs_s0", res_tdata, e_mon.pairs);
                    check(res_tid ? "res_len_s1" : "res_len_s0", res_tlen, e_mon.len);
                end
            end
            clr_exp    = res_tvalid & res_tready;
            stall_prev = res_tvalid & ~res_tready;
            held_data  = res_tdata;
            held_len   = res_tlen;
            held_tid   = res_tid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int  base;
        int  b;
        int  seen;
        bit  rnd_done;
        rst_n = 1'b0;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        eng_tready = 1'b1;
        res_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Simultaneous requests right after reset: s0 wins, first grant on first edge.
        fix0 = '{8'd255, 8'd255};
        fix1 = '{8'd7, 8'd7, 8'd7, 8'd7};
        base = res_log.size();
        fork
            send_frame(0, 2, 0, 1'b1);
            send_frame(1, 4, 0, 1'b1);
            begin
                @(posedge clk); @(negedge clk);
                check("first_grant_s0", s0_tready, 1'b1);
            end
        join
        wait_drain();
        check("tie_first_tid", res_log[base], 0);
        check("tie_second_tid", res_log[base + 1], 1);

        // Both requesters always presenting single-beat frames: grants alternate.
        base = res_log.size();
        fork
            begin repeat (6) send_frame(0, 1, 0, 1'b0); end
            begin repeat (6) send_frame(1, 1, 0, 1'b0); end
        join
        wait_drain();
        for (int k = 0; k < 12; k++) check("alternate_tid", res_log[base + k], k % 2);

        // Five-beat s0 frame with one pair.
        fix0 = '{8'd5, 8'd123, 8'd5, 8'd3, 8'd5};
        send_frame(0, 5, 0, 1'b1);
        wait_drain();

        // Engine backpressure mid-frame holds the beat.
        fix0 = '{8'd1, 8'd2, 8'd1};
        fork
            send_frame(0, 3, 0, 1'b1);
            begin
                b = 100;
                do begin @(negedge clk); b--; end while (!s0_tready && b > 0);
                @(posedge clk); #1 eng_tready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_s0_tready", s0_tready, 1'b0);
                    check("stall_beat_held", {eng_tvalid, eng_tdata}, {1'b1, 8'd2});
                end
                @(posedge clk); #1 eng_tready = 1'b1;
            end
        join
        wait_drain();

        // Result backpressure with s1 waiting.
        res_tready = 1'b0;
        fork
            send_frame(0, 3, 0, 1'b0);
            begin
                wait_res_valid();
                @(posedge clk); #1;
                send_frame(1, 2, 0, 1'b0);
            end
            begin
                wait_res_valid();
                repeat (5) begin
                    @(negedge clk);
                    check("res_stall_valid", res_tvalid, 1'b1);
                    check("res_stall_no_clr", eng_clr, 1'b0);
                    check("res_stall_s1_tready", s1_tready, 1'b0);
                end
                @(posedge clk); #1 res_tready = 1'b1;
            end
        join
        wait_drain();

        // Random traffic with random handshakes; lengths cross saturation.
        rnd_done = 1'b0;
        fork
            begin
                fork
                    begin repeat (25) send_frame(0, $urandom_range(1, 10), $urandom_range(0, 6), 1'b0); end
                    begin repeat (25) send_frame(1, $urandom_range(1, 10), $urandom_range(0, 6), 1'b0); end
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    eng_tready = ($urandom_range(0, 3) != 0);
                    res_tready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        eng_tready = 1'b1;
        res_tready = 1'b1;
        wait_drain();

        // Reset in the middle of an s1 frame, then a clean s0 frame.
        drive(1, 1'b1, 8'd5, 1'b0);
        seen = 0;
        b = 100;
        while (seen < 2 && b > 0) begin
            @(negedge clk);
            if (s1_tready) seen++;
            b--;
        end
        check("partial_beats_seen", seen, 2);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("mid_reset_clr", eng_clr, 1'b1);
        check("mid_reset_outputs",
              {s0_tready, s1_tready, eng_tvalid, res_tvalid, res_tid, res_tdata, res_tlen}, 0);
        drive(1, 1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        fix0 = '{8'd9, 8'd9};
        base = res_log.size();
        fork
            send_frame(0, 2, 0, 1'b1);
            begin
                @(posedge clk); @(negedge clk);
                check("grant_after_reset", s0_tready, 1'b1);
            end
        join
        wait_drain();
        check("after_reset_tid", res_log[base], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
